dds_dac_spi: RTL and testbench

Downstream stage of the DDS top. Consumes each 16-bit sine sample and its one-cycle ready strobe, then serialises it to an external SPI DAC as a 24-bit frame: an 8-bit command followed by the 16-bit sample. A one-deep pending register absorbs one sample that arrives while a frame is in flight. Further samples overwrite the pending one and raise a sticky overrun flag.

---
 rtl/dds_dac_spi.sv | 170 +++++++++++++++++
 tb/tb_dds_dac_spi.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_dac_spi.sv
// dds_dac_spi: serialises 16-bit DDS samples to an SPI DAC (mode 0).
// Each frame is 24 bits, sent MSB first: {CMD, sample'}.
// A one-deep pending register holds one sample that arrives mid-frame.
// Optional build macro DAC_OFFSET_BINARY_EN: sends the sample as offset binary
// (MSB inverted) instead of two's complement. Framing and timing do not change.
//
// Handshake: sample_valid is a one-cycle strobe with no back-pressure.
//   - IDLE: a strobe starts a frame.
//   - SHIFT or GAP: a strobe is parked in pending. A newer strobe overwrites it
//     and sets the sticky overrun flag.
//
// Timing: one SHIFT frame is 48 half-bit periods (6-bit half_q), each CLK_DIV
// clk cycles long. spi_sclk is half_q[0]. The shift register advances on the
// cycle sclk falls, so spi_mosi is stable while spi_sclk is high.
// The FSM state is exported on dbg_state_o for checkers.
module dds_dac_spi #(
    parameter int         CLK_DIV = 2,
    parameter int         CS_HIGH = 2,
    parameter logic [7:0] CMD     = 8'h30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        busy,
    output logic        overrun,
    output logic        frame_done,
    output logic [1:0]  dbg_state_o
);

    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(CS_HIGH) + 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_HIGH - 1);
    localparam logic [5:0]    HALF_LAST = 6'd47;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   shift_q, shift_d;
    logic [5:0]    half_q, half_d;
    logic [DW-1:0] div_q, div_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic          ovr_q, ovr_d;
    logic          load;
    logic [15:0]   load_val;

    // Sample format conversion applied when a sample enters the shift register.
    function automatic logic [15:0] conv(input logic [15:0] s);
`ifdef DAC_OFFSET_BINARY_EN
        return {~s[15], s[14:0]};
`else
        return s;
`endif
    endfunction

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            half_q   <= '0;
            div_q    <= '0;
            gap_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            half_q   <= half_d;
            div_q    <= div_d;
            gap_q    <= gap_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state logic: bit timing, gap timing, pending capture and frame load.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        half_d   = half_q;
        div_d    = div_q;
        gap_d    = gap_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ovr_d    = ovr_q;
        load     = 1'b0;
        load_val = sample;

        // While a frame is in progress, a strobe is parked; overwriting a parked
        // sample is an overrun.
        if (state_q != IDLE && sample_valid) begin
            pend_d   = sample;
            pend_v_d = 1'b1;
            if (pend_v_q) begin
                ovr_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (half_q == HALF_LAST) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        half_d = half_q + 6'd1;
                        // Leaving a high phase: present the next bit as sclk falls.
                        if (half_q[0]) begin
                            shift_d = {shift_q[22:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    // A strobe on this cycle is newer than anything parked.
                    if (sample_valid || pend_v_q) begin
                        load     = 1'b1;
                        load_val = sample_valid ? sample : pend_q;
                        pend_v_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d = SHIFT;
            shift_d = {CMD, conv(load_val)};
            half_d  = '0;
            div_d   = '0;
        end
    end

    assign busy        = (state_q != IDLE);
    assign spi_cs_n    = (state_q != SHIFT);
    assign spi_sclk    = (state_q == SHIFT) && half_q[0];
    assign spi_mosi    = (state_q == SHIFT) && shift_q[23];
    assign frame_done  = (state_q == GAP) && (gap_q == '0);
    assign overrun     = ovr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dds_dac_spi.sv
// tb_dds_dac_spi: directed test of dds_dac_spi.
// dut0 uses CLK_DIV=2 and CS_HIGH=2. dut1 uses CLK_DIV=1 and CS_HIGH=1.
// "Cycle n" is the value of cyc when the bench observes the design;
// a strobe driven while cyc==n is sampled at the end of cycle n.
module tb_dds_dac_spi;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample0, sample1;
    logic        valid0, valid1;
    logic        sclk0, mosi0, cs0, busy0, ovr0, fd0;
    logic        sclk1, mosi1, cs1, busy1, ovr1, fd1;
    logic [1:0]  dbg0, dbg1;
    int          cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed frames; the offset-binary build inverts sample bit 15.
`ifdef DAC_OFFSET_BINARY_EN
    localparam logic [23:0] F8001 = 24'h300001;
    localparam logic [23:0] F7FFF = 24'h30FFFF;
    localparam logic [23:0] F1234 = 24'h309234;
    localparam logic [23:0] F5678 = 24'h30D678;
    localparam logic [23:0] F0F0F = 24'h308F0F;
    localparam logic [23:0] FC3C3 = 24'h3043C3;
    localparam logic [23:0] FAAAA = 24'h302AAA;
    localparam logic [23:0] F0002 = 24'h308002;
    localparam logic [23:0] F4321 = 24'h30C321;
    localparam logic [23:0] FBEEF = 24'h303EEF;
`else
    localparam logic [23:0] F8001 = 24'h308001;
    localparam logic [23:0] F7FFF = 24'h307FFF;
    localparam logic [23:0] F1234 = 24'h301234;
    localparam logic [23:0] F5678 = 24'h305678;
    localparam logic [23:0] F0F0F = 24'h300F0F;
    localparam logic [23:0] FC3C3 = 24'h30C3C3;
    localparam logic [23:0] FAAAA = 24'h30AAAA;
    localparam logic [23:0] F0002 = 24'h300002;
    localparam logic [23:0] F4321 = 24'h304321;
    localparam logic [23:0] FBEEF = 24'h30BEEF;
`endif

    dds_dac_spi dut0 (
        .clk(clk), .reset(reset), .sample(sample0), .sample_valid(valid0),
        .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_cs_n(cs0), .busy(busy0),
        .overrun(ovr0), .frame_done(fd0), .dbg_state_o(dbg0)
    );

    dds_dac_spi #(.CLK_DIV(1), .CS_HIGH(1), .CMD(8'h30)) dut1 (
        .clk(clk), .reset(reset), .sample(sample1), .sample_valid(valid1),
        .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_cs_n(cs1), .busy(busy1),
        .overrun(ovr1), .frame_done(fd1), .dbg_state_o(dbg1)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI monitor for both instances, sampled on the falling clk edge.
    logic        cs_v[2], sclk_v[2], mosi_v[2], fd_v[2], busy_v[2], ovr_v[2];
    logic        p_cs[2], p_sclk[2], p_mosi[2], p_busy[2], p_ovr[2];
    logic [23:0] sh[2];
    int          nbit[2], lowc[2], viol[2];
    int          nfr[2], nfall[2], nfd[2];
    logic [23:0] frames[2][4];
    int          fr_low[2][4], fr_nb[2][4], fall_c[2][4], fd_c[2][4];
    int          busy_fall[2], ovr_rise[2];

    assign cs_v[0] = cs0;    assign cs_v[1] = cs1;
    assign sclk_v[0] = sclk0; assign sclk_v[1] = sclk1;
    assign mosi_v[0] = mosi0; assign mosi_v[1] = mosi1;
    assign fd_v[0] = fd0;    assign fd_v[1] = fd1;
    assign busy_v[0] = busy0; assign busy_v[1] = busy1;
    assign ovr_v[0] = ovr0;  assign ovr_v[1] = ovr1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            p_cs[i] = 1'b1; p_sclk[i] = 1'b0; p_mosi[i] = 1'b0;
            p_busy[i] = 1'b0; p_ovr[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!cs_v[i] && p_cs[i]) begin
                if (nfall[i] < 4) fall_c[i][nfall[i]] = cyc;
                nfall[i]++;
                sh[i] = '0; nbit[i] = 0; lowc[i] = 0;
            end
            if (!cs_v[i]) lowc[i]++;
            if (sclk_v[i] && !p_sclk[i]) begin
                sh[i] = {sh[i][22:0], mosi_v[i]};
                nbit[i]++;
            end
            if (sclk_v[i] && p_sclk[i] && (mosi_v[i] != p_mosi[i])) viol[i]++;
            if (sclk_v[i] && cs_v[i]) viol[i]++;
            if (cs_v[i] && !p_cs[i]) begin
                if (nfr[i] < 4) begin
                    frames[i][nfr[i]] = sh[i];
                    fr_low[i][nfr[i]] = lowc[i];
                    fr_nb[i][nfr[i]]  = nbit[i];
                end
                nfr[i]++;
            end
            if (fd_v[i]) begin
                if (nfd[i] < 4) fd_c[i][nfd[i]] = cyc;
                nfd[i]++;
            end
            if (!busy_v[i] && p_busy[i]) busy_fall[i] = cyc;
            if (ovr_v[i] && !p_ovr[i]) ovr_rise[i] = cyc;
            p_cs[i] = cs_v[i]; p_sclk[i] = sclk_v[i]; p_mosi[i] = mosi_v[i];
            p_busy[i] = busy_v[i]; p_ovr[i] = ovr_v[i];
        end
    end

    // Single comparison point for every check.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Driver tasks; all bench activity happens 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_to(input int e);
        while (cyc < e) step();
    endtask

    task automatic pulse_at(input int inst, input int e, input logic [15:0] val);
        run_to(e);
        if (inst == 0) begin sample0 = val; valid0 = 1'b1; end
        else begin sample1 = val; valid1 = 1'b1; end
        step();
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            nfr[i] = 0; nfall[i] = 0; nfd[i] = 0; viol[i] = 0;
            busy_fall[i] = -1; ovr_rise[i] = -1;
        end
    endtask

    int t0;

    initial begin
        reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0; sample0 = '0; sample1 = '0;
        clear_mon();
        repeat (3) step();
        reset = 1'b0;
        step();
        check_eq("rst_cs_n", cs0, 1'b1);
        check_eq("rst_sclk", sclk0, 1'b0);
        check_eq("rst_mosi", mosi0, 1'b0);
        check_eq("rst_busy", busy0, 1'b0);
        check_eq("rst_overrun", ovr0, 1'b0);
        check_eq("rst_frame_done", fd0, 1'b0);
        check_eq("rst_state", dbg0, 2'd0);
        check_eq("rst_cs_n_div1", cs1, 1'b1);

        // Single frame, full timing.
        clear_mon();
        t0 = cyc + 2;
        pulse_at(0, t0, 16'h8001);
        run_to(t0 + 110);
        check_eq("a_frames", nfr[0], 1);
        check_eq("a_frame", frames[0][0], F8001);
        check_eq("a_bits", fr_nb[0][0], 24);
        check_eq("a_cs_low_len", fr_low[0][0], 96);
        check_eq("a_cs_fall", fall_c[0][0] - t0, 1);
        check_eq("a_done_cnt", nfd[0], 1);
        check_eq("a_done_cyc", fd_c[0][0] - t0, 97);
        check_eq("a_busy_fall", busy_fall[0] - t0, 99);
        check_eq("a_mosi_stable", viol[0], 0);

        // Positive full-scale sample.
        clear_mon();
        t0 = cyc + 2;
        pulse_at(0, t0, 16'h7FFF);
        run_to(t0 + 110);
        check_eq("b_frame", frames[0][0], F7FFF);

        // Second sample parked while the first is in flight.
        clear_mon();
        t0 = cyc + 2;
        pulse_at(0, t0, 16'h1234);
        pulse_at(0, t0 + 10, 16'h5678);
        run_to(t0 + 205);
        check_eq("c_frames", nfr[0], 2);
        check_eq("c_frame0", frames[0][0], F1234);
        check_eq("c_frame1", frames[0][1], F5678);
        check_eq("c_cs_fall1", fall_c[0][1] - t0, 99);
        check_eq("c_done_cnt", nfd[0], 2);
        check_eq("c_overrun", ovr0, 1'b0);

        // Strobe on the final gap cycle starts the next frame at once.
        clear_mon();
        t0 = cyc + 2;
        pulse_at(0, t0, 16'h0F0F);
        pulse_at(0, t0 + 98, 16'hC3C3);
        run_to(t0 + 205);
        check_eq("d_frames", nfr[0], 2);
        check_eq("d_frame1", frames[0][1], FC3C3);
        check_eq("d_cs_fall1", fall_c[0][1] - t0, 99);
        check_eq("d_frame0", frames[0][0], F0F0F);

        // Overwritten pending sample sets the sticky overrun flag.
        clear_mon();
        t0 = cyc + 2;
        pulse_at(0, t0, 16'hAAAA);
        pulse_at(0, t0 + 5, 16'h0001);
        pulse_at(0, t0 + 6, 16'h0002);
        run_to(t0 + 205);
        check_eq("e_frames", nfr[0], 2);
        check_eq("e_frame0", frames[0][0], FAAAA);
        check_eq("e_frame1", frames[0][1], F0002);
        check_eq("e_ovr_rise", ovr_rise[0] - t0, 7);
        check_eq("e_ovr_sticky", ovr0, 1'b1);

        // Reset mid-frame drops the frame and the parked sample.
        clear_mon();
        t0 = cyc + 2;
        pulse_at(0, t0, 16'h1111);
        pulse_at(0, t0 + 10, 16'h2222);
        run_to(t0 + 40);
        reset = 1'b1;
        step();
        check_eq("f_cs_n", cs0, 1'b1);
        check_eq("f_sclk", sclk0, 1'b0);
        check_eq("f_mosi", mosi0, 1'b0);
        check_eq("f_busy", busy0, 1'b0);
        check_eq("f_overrun", ovr0, 1'b0);
        reset = 1'b0;
        clear_mon();
        run_to(t0 + 250);
        check_eq("f_no_frame", nfall[0], 0);
        check_eq("f_idle", busy0, 1'b0);
        t0 = cyc + 2;
        pulse_at(0, t0, 16'h4321);
        run_to(t0 + 110);
        check_eq("f_new_frames", nfr[0], 1);
        check_eq("f_new_frame", frames[0][0], F4321);
        check_eq("f_new_len", fr_low[0][0], 96);

        // Fastest settings on dut1.
        clear_mon();
        t0 = cyc + 2;
        pulse_at(1, t0, 16'hBEEF);
        run_to(t0 + 60);
        check_eq("g_frame", frames[1][0], FBEEF);
        check_eq("g_bits", fr_nb[1][0], 24);
        check_eq("g_cs_fall", fall_c[1][0] - t0, 1);
        check_eq("g_cs_low_len", fr_low[1][0], 48);
        check_eq("g_done_cyc", fd_c[1][0] - t0, 49);
        check_eq("g_busy_fall", busy_fall[1] - t0, 50);
        check_eq("g_mosi_stable", viol[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
